// File: rtl/risc_kgp_pkg.sv
// Shared definitions for the RISC_KGP datapath: shift opcodes and machine width.
package risc_kgp_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SH_SLL  = 2'd0,
    SH_SRL  = 2'd1,
    SH_SRA  = 2'd2,
    SH_PASS = 2'd3
  } shift_op_t;

endpackage

// File: rtl/BarrelShifter.sv
// Five-level logarithmic barrel shifter; dir=1 shifts left, right shifts fill with feedinbit.
module BarrelShifter (
  input  logic [31:0] in,
  input  logic [4:0]  shamt,
  input  logic        dir,
  input  logic        feedinbit,
  output logic [31:0] out
);

  logic [5:0][31:0] lvl;

  assign lvl[0] = in;

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_lvl
      localparam int K = 1 << gi;
      logic [31:0] sh_left;
      logic [31:0] sh_right;
      assign sh_left  = lvl[gi] << K;
      assign sh_right = (lvl[gi] >> K) | ({32{feedinbit}} << (32 - K));
      assign lvl[gi+1] = shamt[gi] ? (dir ? sh_left : sh_right) : lvl[gi];
    end
  endgenerate

  assign out = lvl[5];

endmodule

// File: rtl/shift_core.sv
// Combinational result/carry resolution, including amounts of 32 and above.
module shift_core
  import risc_kgp_pkg::*;
(
  input  shift_op_t   op,
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  input  logic        big,
  input  logic        eq32,
  output logic [31:0] result,
  output logic        carry
);

  logic [31:0] bs_out;
  logic [4:0]  left_idx;
  logic [4:0]  right_idx;

  BarrelShifter u_bs (
    .in        (a),
    .shamt     (shamt),
    .dir       (op == SH_SLL),
    .feedinbit ((op == SH_SRA) & a[31]),
    .out       (bs_out)
  );

  // Modulo-32 arithmetic gives 32-s and s-1 for s in 1..31.
  assign left_idx  = 5'd0 - shamt;
  assign right_idx = shamt - 5'd1;

  always_comb begin
    result = bs_out;
    carry  = 1'b0;
    unique case (op)
      SH_SLL: begin
        if (big) begin
          result = '0;
          carry  = eq32 & a[0];
        end else begin
          carry = (shamt != 5'd0) & a[left_idx];
        end
      end
      SH_SRL: begin
        if (big) begin
          result = '0;
          carry  = eq32 & a[31];
        end else begin
          carry = (shamt != 5'd0) & a[right_idx];
        end
      end
      SH_SRA: begin
        if (big) begin
          result = {32{a[31]}};
          carry  = a[31];
        end else begin
          carry = (shamt != 5'd0) & a[right_idx];
        end
      end
      default: begin
        result = a;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage shift execution pipeline: operand register, then result/flag register,
// with a valid/ready handshake on each side and a synchronous flush.
module shift_exec_stage
  import risc_kgp_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_op,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         out_zero,
  output logic         out_carry
);

  logic        s1_valid_q;
  shift_op_t   op_q;
  logic [31:0] a_q;
  logic [4:0]  shamt_q;
  logic        big_q;
  logic        eq32_q;

  logic        out_valid_q;
  logic [31:0] result_q;
  logic        zero_q;
  logic        carry_q;

  logic        adv1;
  logic        adv2;
  logic        accept;
  logic        load2;
  logic [31:0] result_d;
  logic        carry_d;

  assign adv2   = !out_valid_q || out_ready;
  assign adv1   = !s1_valid_q || adv2;
  assign accept = in_valid && adv1;
  assign load2  = s1_valid_q && adv2;

  shift_core u_core (
    .op     (op_q),
    .a      (a_q),
    .shamt  (shamt_q),
    .big    (big_q),
    .eq32   (eq32_q),
    .result (result_d),
    .carry  (carry_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      op_q        <= SH_SLL;
      a_q         <= '0;
      shamt_q     <= '0;
      big_q       <= 1'b0;
      eq32_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= shift_op_t'(in_op);
        a_q     <= in_a;
        shamt_q <= in_b[4:0];
        big_q   <= |in_b[31:5];
        eq32_q  <= (in_b == 32'd32);
      end
      if (load2) begin
        result_q <= result_d;
        zero_q   <= (result_d == 32'd0);
        carry_q  <= carry_d;
      end
      // Flush wins over any accept or drain happening on the same edge.
      if (flush) begin
        s1_valid_q  <= 1'b0;
        out_valid_q <= 1'b0;
      end else begin
        if (adv1) s1_valid_q <= in_valid;
        if (adv2) out_valid_q <= s1_valid_q;
      end
    end
  end

  assign in_ready   = adv1;
  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_zero   = zero_q;
  assign out_carry  = carry_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed bench for shift_exec_stage: single ops, range edges, streaming with
// backpressure, flush and asynchronous reset mid-stall.
module tb_shift_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_carry;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] OP_SLL = 2'd0, OP_SRL = 2'd1, OP_SRA = 2'd2, OP_PASS = 2'd3;

  shift_exec_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_carry  (out_carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one op, let it travel two edges, check the registered outputs.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_zero, input logic exp_carry);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    step();
    in_valid = 1'b0;
    step();
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".result"}, out_result, exp_res);
    check({tag, ".zero"}, {31'd0, out_zero}, {31'd0, exp_zero});
    check({tag, ".carry"}, {31'd0, out_carry}, {31'd0, exp_carry});
    $display("op %s a=%h b=%h -> result=%h zero=%0b carry=%0b", tag, a, b, out_result, out_zero, out_carry);
    step();
  endtask

  logic [31:0] exp_q[$];
  int          sent;
  int          rcvd;
  int          occ;
  int          cyc;
  logic        fire_in;
  logic        fire_out;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = OP_SLL;
    in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.result", out_result, 32'd0);
    check("rst.zero", {31'd0, out_zero}, 32'd0);
    check("rst.carry", {31'd0, out_carry}, 32'd0);
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);

    run_op("sll4",       OP_SLL,  32'h0000_0001, 32'd4,          32'h0000_0010, 1'b0, 1'b0);
    run_op("sra_big",    OP_SRA,  32'h8000_0000, 32'h100,        32'hFFFF_FFFF, 1'b0, 1'b1);
    run_op("srl_big",    OP_SRL,  32'h8000_0000, 32'h100,        32'h0000_0000, 1'b1, 1'b0);
    run_op("sll32",      OP_SLL,  32'h0000_0001, 32'd32,         32'h0000_0000, 1'b1, 1'b1);
    run_op("srl1",       OP_SRL,  32'h0000_0003, 32'd1,          32'h0000_0001, 1'b0, 1'b1);
    run_op("srl32",      OP_SRL,  32'h8000_0000, 32'd32,         32'h0000_0000, 1'b1, 1'b1);
    run_op("sra32pos",   OP_SRA,  32'h7FFF_FFFF, 32'd32,         32'h0000_0000, 1'b1, 1'b0);
    run_op("sll_hi_big", OP_SLL,  32'h0000_0001, 32'hFFFF_FFE1,  32'h0000_0000, 1'b1, 1'b0);
    run_op("sll31",      OP_SLL,  32'h0000_0003, 32'd31,         32'h8000_0000, 1'b0, 1'b1);
    run_op("srl31",      OP_SRL,  32'h8000_0000, 32'd31,         32'h0000_0001, 1'b0, 1'b0);
    run_op("sra4",       OP_SRA,  32'hF000_0008, 32'd4,          32'hFF00_0000, 1'b0, 1'b1);
    run_op("sll0",       OP_SLL,  32'h8000_0001, 32'd0,          32'h8000_0001, 1'b0, 1'b0);
    run_op("pass",       OP_PASS, 32'h1234_5678, 32'd5,          32'h1234_5678, 1'b0, 1'b0);

    // Stream of 8 SLL ops with out_ready low on cycles 3..5.
    sent = 0; rcvd = 0; occ = 0; exp_q.delete();
    for (cyc = 0; cyc < 40 && rcvd < 8; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid  = (sent < 8);
      in_op     = OP_SLL;
      in_a      = 32'(sent + 1);
      in_b      = 32'(sent);
      @(negedge clk);
      check($sformatf("stream.in_ready[c%0d]", cyc), {31'd0, in_ready},
            {31'd0, !(occ == 2 && !out_ready)});
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        if (exp_q.size() == 0) begin
          check("stream.spurious", 32'd1, 32'd0);
        end else begin
          check($sformatf("stream.result[%0d]", rcvd), out_result, exp_q[0]);
          $display("stream out #%0d result=%h", rcvd, out_result);
          void'(exp_q.pop_front());
        end
        rcvd++;
      end
      if (fire_in) begin
        exp_q.push_back(32'(sent + 1) << sent);
        sent++;
      end
      occ = occ + (fire_in ? 1 : 0) - (fire_out ? 1 : 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream.count", 32'(rcvd), 32'd8);
    step();
    check("stream.drained", {31'd0, out_valid}, 32'd0);

    // Fill both stages under stall, then flush with a new op offered.
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = OP_SLL; in_a = 32'h1; in_b = 32'd1;
    step();
    in_a = 32'h2;
    step();
    check("flush.full_in_ready", {31'd0, in_ready}, 32'd0);
    check("flush.full_out_valid", {31'd0, out_valid}, 32'd1);
    in_op = OP_PASS; in_a = 32'hDEAD_BEEF; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush.out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("flush.no_emerge[%0d]", i), {31'd0, out_valid}, 32'd0);
      step();
    end
    $display("flush done");

    // Stall with a result held, then assert rst_n between edges.
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = OP_SLL; in_a = 32'hF; in_b = 32'd4;
    step();
    in_a = 32'h3;
    step();
    in_valid = 1'b0;
    check("arst.pre_result", out_result, 32'h0000_00F0);
    #2 rst_n = 1'b0;
    #1;
    check("arst.out_valid", {31'd0, out_valid}, 32'd0);
    check("arst.result", out_result, 32'd0);
    check("arst.carry", {31'd0, out_carry}, 32'd0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("arst.in_ready", {31'd0, in_ready}, 32'd1);
    $display("async reset done");
    run_op("recover", OP_SRL, 32'h0000_0100, 32'd8, 32'h0000_0001, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
